// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte holding register, valid/ack handshake,
// a one-cycle framing-error pulse and a sticky overrun flag.
`timescale 1ns/1ps
module uart_receiver #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       reset,
    input  logic       i_Rx_Serial,
    input  logic       i_Rx_Ack,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_DV,
    output logic       o_Rx_Active,
    output logic       o_Framing_Error,
    output logic       o_Rx_Overrun
);
    // state     | meaning
    // WAIT_HIGH | line not yet seen idle (after reset or a framing error)
    // IDLE      | line idle, looking for a start bit
    // START     | half-bit wait to confirm the start bit
    // DATA      | sampling the 8 data bits at bit centres
    // STOP      | sampling the stop bit, then deliver, overrun or error
    typedef enum logic [2:0] {
        WAIT_HIGH = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } state_t;

    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        active_q, active_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic [1:0]  sync_q, sync_d;
    logic [1:0]  settle_q, settle_d;
    logic        rx_s;
    logic        rx_ok;

    assign rx_s  = sync_q[1];
    // The synchronizer resets to idle-high, so its output only reflects the
    // real line once it has been refilled after reset release.
    assign rx_ok = settle_q[1];

    always_comb begin
        sync_d   = {sync_q[0], i_Rx_Serial};
        settle_d = {settle_q[0], 1'b1};
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sh_d     = sh_q;
        byte_d   = byte_q;
        dv_d     = dv_q;
        active_d = active_q;
        ferr_d   = 1'b0;
        ovr_d    = ovr_q;

        if (i_Rx_Ack) begin
            dv_d  = 1'b0;
            ovr_d = 1'b0;
        end

        case (state_q)
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_ok && rx_s) state_d = IDLE;
            end
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    if (rx_s) begin
                        state_d = IDLE;
                        // A same-cycle ack frees the register for the new byte.
                        if (!dv_q || i_Rx_Ack) begin
                            byte_d = sh_q;
                            dv_d   = 1'b1;
                            ovr_d  = 1'b0;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        state_d = WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d  = WAIT_HIGH;
                cnt_d    = '0;
                idx_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_HIGH;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sync_q   <= 2'b11;
            settle_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            active_q <= active_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            sync_q   <= sync_d;
            settle_q <= settle_d;
        end
    end

    assign o_Rx_Byte       = byte_q;
    assign o_Rx_DV         = dv_q;
    assign o_Rx_Active     = active_q;
    assign o_Framing_Error = ferr_q;
    assign o_Rx_Overrun    = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames are generated in real
// time from bit periods, expected bytes come from a queue-based model.
`timescale 1ns/1ps
module tb_uart_receiver;
    localparam int  CPB    = 16;
    localparam real CLK_NS = 10.0;
    localparam real BIT_NS = CPB * CLK_NS;
    localparam int  HALF   = (CPB - 1) / 2;
    localparam int  LAT    = 3 + HALF + 1 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] rx_byte;
    logic       dv, active, ferr, ovr;

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cycles   = 0;
    int active_cycles = 0;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .reset          (rst),
        .i_Rx_Serial    (rx),
        .i_Rx_Ack       (ack),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_DV        (dv),
        .o_Rx_Active    (active),
        .o_Framing_Error(ferr),
        .o_Rx_Overrun   (ovr)
    );

    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_cycles++;
        if (active === 1'b1) active_cycles++;
    end

    // Drives start, 8 data bits LSB first and the stop bit; leaves the line at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input real bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop_bit;
        #(bit_ns);
    endtask

    task automatic wait_dv(input int max_cyc, output bit timed_out, output realtime t_seen);
        timed_out = 1'b1;
        t_seen    = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (dv === 1'b1) begin
                timed_out = 1'b0;
                t_seen    = $realtime;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one nominal-rate frame aligned to a falling clock edge and checks delivery and latency.
    task automatic send_and_expect(input logic [7:0] b, input string tag);
        realtime t0, t_seen;
        bit      to;
        int      lat, f0;
        f0 = ferr_cycles;
        @(negedge clk);
        t0 = $realtime;
        fork
            send_frame(b, 1'b1, BIT_NS);
            wait_dv(LAT + 40, to, t_seen);
        join
        rx = 1'b1;
        n_checks++;
        if (to) begin
            n_fail++;
            $display("FAIL %s_dv_timeout: o_Rx_DV never rose, want rise after ~%0d clocks", tag, LAT);
        end else begin
            lat = int'((t_seen - t0) / CLK_NS);
            n_checks++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d clocks want %0d+-1", tag, lat, LAT);
            end
        end
        n_checks++;
        if (rx_byte !== b) begin
            n_fail++;
            $display("FAIL %s_byte: got %h want %h", tag, rx_byte, b);
        end
        n_checks++;
        if (ferr_cycles != f0) begin
            n_fail++;
            $display("FAIL %s_no_ferr: got %0d pulses want 0", tag, ferr_cycles - f0);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (rx_byte !== 8'h00 || dv !== 1'b0 || active !== 1'b0 || ferr !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got byte=%h dv=%b act=%b ferr=%b ovr=%b want all 0",
                     rx_byte, dv, active, ferr, ovr);
        end
        idle(3);
        rst = 1'b0;
        idle(5);
        n_checks++;
        if (dv !== 1'b0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got dv=%b act=%b want 0 0", dv, active);
        end
    endtask

    task automatic test_single(input logic [7:0] b);
        send_and_expect(b, "single");
        idle(5);
        n_checks++;
        if (ovr !== 1'b0 || dv !== 1'b1) begin
            n_fail++;
            $display("FAIL single_flags: got dv=%b ovr=%b want 1 0", dv, ovr);
        end
        pulse_ack();
        n_checks++;
        if (dv !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got dv=%b want 0", dv);
        end
        idle(5);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int f0;
        bytes[0] = 8'h00;
        bytes[1] = 8'hFF;
        bytes[2] = 8'h55;
        f0 = ferr_cycles;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, BIT_NS);
                rx = 1'b1;
            end
            begin
                bit to;
                realtime ts;
                for (int i = 0; i < 3; i++) begin
                    wait_dv(2 * LAT, to, ts);
                    n_checks++;
                    if (to || rx_byte !== bytes[i]) begin
                        n_fail++;
                        $display("FAIL b2b_byte%0d: got %h (timeout=%0b) want %h", i, rx_byte, to, bytes[i]);
                    end
                    idle(5);
                    pulse_ack();
                end
            end
        join
        idle(20);
        n_checks++;
        if (ovr !== 1'b0 || ferr_cycles != f0 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_flags: got ovr=%b ferr_pulses=%0d dv=%b want 0 0 0", ovr, ferr_cycles - f0, dv);
        end
    endtask

    task automatic test_overrun();
        send_and_expect(8'h12, "ovr_first");
        idle(10);
        send_frame(8'h34, 1'b1, BIT_NS);
        rx = 1'b1;
        idle(10);
        n_checks++;
        if (rx_byte !== 8'h12 || dv !== 1'b1 || ovr !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got byte=%h dv=%b ovr=%b want 12 1 1", rx_byte, dv, ovr);
        end
        pulse_ack();
        n_checks++;
        if (dv !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_ack: got dv=%b ovr=%b want 0 0", dv, ovr);
        end
        idle(5);
        send_and_expect(8'h56, "ovr_refill");
        idle(10);
        // Ack lands exactly on the stop-sample clock edge of the next frame.
        @(negedge clk);
        fork
            send_frame(8'h78, 1'b1, BIT_NS);
            begin
                #(CLK_NS * (LAT - 1));
                ack = 1'b1;
                #(CLK_NS);
                ack = 1'b0;
            end
        join
        rx = 1'b1;
        idle(2);
        n_checks++;
        if (rx_byte !== 8'h78 || dv !== 1'b1 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_coincide: got byte=%h dv=%b ovr=%b want 78 1 0", rx_byte, dv, ovr);
        end
        pulse_ack();
        idle(5);
    endtask

    task automatic test_framing();
        int f0, a0;
        f0 = ferr_cycles;
        @(negedge clk);
        send_frame(8'h3C, 1'b0, BIT_NS);
        a0 = active_cycles;
        idle(40);
        n_checks++;
        if (ferr_cycles - f0 != 1) begin
            n_fail++;
            $display("FAIL framing_pulse: got %0d error cycles want 1", ferr_cycles - f0);
        end
        n_checks++;
        if (dv !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_no_dv: got dv=%b ovr=%b want 0 0", dv, ovr);
        end
        n_checks++;
        if (active_cycles != a0) begin
            n_fail++;
            $display("FAIL framing_wait_high: got %0d active cycles while low want 0", active_cycles - a0);
        end
        rx = 1'b1;
        idle(20);
        send_and_expect(8'h81, "framing_next");
        pulse_ack();
        idle(5);
    endtask

    task automatic test_glitch();
        int f0, a0;
        f0 = ferr_cycles;
        a0 = active_cycles;
        @(negedge clk);
        rx = 1'b0;
        #(4 * CLK_NS);
        rx = 1'b1;
        idle(40);
        n_checks++;
        if (active_cycles - a0 != HALF + 1) begin
            n_fail++;
            $display("FAIL glitch_active: got %0d active cycles want %0d", active_cycles - a0, HALF + 1);
        end
        n_checks++;
        if (dv !== 1'b0 || ferr_cycles != f0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_flags: got dv=%b ferr_pulses=%0d act=%b want 0 0 0",
                     dv, ferr_cycles - f0, active);
        end
    endtask

    // Random bytes at a random baud mismatch within +-3%, checked against an expected-byte queue.
    task automatic test_random(input int n);
        logic [7:0] exp_q[$];
        int f0;
        f0 = ferr_cycles;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [7:0] b;
                    real f, gap;
                    b   = 8'($urandom);
                    f   = 0.97 + 0.06 * real'($urandom_range(0, 1000)) / 1000.0;
                    gap = BIT_NS * (0.5 + real'($urandom_range(0, 2)));
                    exp_q.push_back(b);
                    send_frame(b, 1'b1, BIT_NS * f);
                    rx = 1'b1;
                    #(gap);
                end
            end
            begin
                bit to;
                realtime ts;
                logic [7:0] want;
                for (int i = 0; i < n; i++) begin
                    wait_dv(600, to, ts);
                    want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    n_checks++;
                    if (to || rx_byte !== want) begin
                        n_fail++;
                        $display("FAIL random_byte%0d: got %h (timeout=%0b) want %h", i, rx_byte, to, want);
                    end
                    idle($urandom_range(1, 5));
                    pulse_ack();
                end
            end
        join
        idle(20);
        n_checks++;
        if (ovr !== 1'b0 || ferr_cycles != f0) begin
            n_fail++;
            $display("FAIL random_flags: got ovr=%b ferr_pulses=%0d want 0 0", ovr, ferr_cycles - f0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] first, c3;
        int a0;
        first = 8'($urandom) | 8'h01;
        c3    = 8'hC3;
        send_and_expect(first, "rstmid_fill");
        idle(10);
        @(negedge clk);
        rx = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 3; i++) begin
            rx = c3[i];
            #(BIT_NS);
        end
        rx = 1'b0;
        #(BIT_NS / 2 + 3.0);
        n_checks++;
        if (active !== 1'b1 || dv !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_before: got act=%b dv=%b want 1 1", active, dv);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rx_byte !== 8'h00 || dv !== 1'b0 || active !== 1'b0 || ferr !== 1'b0 || ovr !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_clear: got byte=%h dv=%b act=%b ferr=%b ovr=%b want all 0",
                     rx_byte, dv, active, ferr, ovr);
        end
        #(23.0);
        rst = 1'b0;
        a0 = active_cycles;
        idle(200);
        n_checks++;
        if (active_cycles != a0 || dv !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_start: got %0d active cycles dv=%b want 0 0", active_cycles - a0, dv);
        end
        rx = 1'b1;
        idle(20);
        send_and_expect(8'h7E, "rstmid_next");
        pulse_ack();
        idle(5);
    endtask

    initial begin
        test_reset();
        test_single(8'hA5);
        test_single(8'($urandom));
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_random(8);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL global_timeout: simulation still running at 5 ms");
        $fatal(1, "timeout");
    end

endmodule
